// File: rtl/delay_line_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_line_if
// Brief    : Control, data and status bundle for the delay_line pipeline.
// Revision : 1.0
// ============================================================================
interface delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TAP_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic             rotate;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [TAP_W-1:0] tap_sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [WIDTH-1:0] tap_q;
    logic             tap_valid;
    logic [CNT_W-1:0] fill_cnt;
    logic             full;
    logic             empty;

    modport master (
        output en, flush, rotate, d, d_valid, tap_sel,
        input  q, q_valid, tap_q, tap_valid, fill_cnt, full, empty
    );

    modport slave (
        input  en, flush, rotate, d, d_valid, tap_sel,
        output q, q_valid, tap_q, tap_valid, fill_cnt, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Brief    : DEPTH-stage data/valid pipeline with rotate, flush, tap and fill.
// Revision : 1.0
// ============================================================================
module delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    delay_line_if.slave bus
);
    localparam int TAP_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] w_fill_nxt;
    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_valid;

    // Flush clears only the valid bits; data words are left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else if (bus.flush) begin
            r_valid <= '0;
        end else if (bus.en) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            if (bus.rotate) begin
                r_data[0]  <= r_data[DEPTH-1];
                r_valid[0] <= r_valid[DEPTH-1];
            end else begin
                r_data[0]  <= bus.d;
                r_valid[0] <= bus.d_valid;
            end
        end
    end

    always_comb begin
        w_fill_nxt = r_fill;
        if (bus.flush) begin
            w_fill_nxt = '0;
        end else if (bus.en && !bus.rotate) begin
            w_fill_nxt = r_fill + CNT_W'(bus.d_valid) - CNT_W'(r_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
        end else begin
            r_fill <= w_fill_nxt;
        end
    end

    // Out-of-range selects match no stage and fall through to zero.
    always_comb begin
        w_tap_q     = '0;
        w_tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.tap_sel == TAP_W'(i)) begin
                w_tap_q     = r_data[i];
                w_tap_valid = r_valid[i];
            end
        end
    end

    assign bus.q         = r_data[DEPTH-1];
    assign bus.q_valid   = r_valid[DEPTH-1];
    assign bus.tap_q     = w_tap_q;
    assign bus.tap_valid = w_tap_valid;
    assign bus.fill_cnt  = r_fill;
    assign bus.full      = (r_fill == CNT_W'(DEPTH));
    assign bus.empty     = (r_fill == '0);
endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line
// Brief    : Directed self-checking bench for delay_line (DEPTH=4 and DEPTH=5).
// Revision : 1.0
// ============================================================================
module tb_delay_line;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] pv_d [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    logic       pv_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int         pv_f [5] = '{1, 1, 2, 3, 3};

    delay_line_if #(.WIDTH(8), .DEPTH(4)) b4 ();
    delay_line_if #(.WIDTH(8), .DEPTH(5)) b5 ();

    delay_line #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    delay_line #(.WIDTH(8), .DEPTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        b4.en = 1'b0; b4.flush = 1'b0; b4.rotate = 1'b0; b4.d = '0; b4.d_valid = 1'b0; b4.tap_sel = '0;
        b5.en = 1'b0; b5.flush = 1'b0; b5.rotate = 1'b0; b5.d = '0; b5.d_valid = 1'b0; b5.tap_sel = '0;
        #2;
        chk("rst_q",         32'(b4.q),         0);
        chk("rst_q_valid",   32'(b4.q_valid),   0);
        chk("rst_fill",      32'(b4.fill_cnt),  0);
        chk("rst_empty",     32'(b4.empty),     1);
        chk("rst_full",      32'(b4.full),      0);
        chk("rst_tap_q",     32'(b4.tap_q),     0);
        chk("rst_tap_valid", 32'(b4.tap_valid), 0);
        rst_n = 1'b1;

        // Async reset mid-operation
        b4.en = 1'b1; b4.d_valid = 1'b1;
        b4.d = 8'h11; tick;
        b4.d = 8'h22; tick;
        b4.d = 8'h33; tick;
        chk("pre_rst_fill", 32'(b4.fill_cnt), 3);
        b4.tap_sel = 2'd2; #1;
        chk("pre_rst_tap_q", 32'(b4.tap_q), 'h11);
        rst_n = 1'b0; #1;
        chk("arst_q",       32'(b4.q),        0);
        chk("arst_q_valid", 32'(b4.q_valid),  0);
        chk("arst_fill",    32'(b4.fill_cnt), 0);
        chk("arst_empty",   32'(b4.empty),    1);
        chk("arst_tap_q",   32'(b4.tap_q),    0);
        b4.en = 1'b0;
        rst_n = 1'b1;

        // Fill and latency
        b4.en = 1'b1; b4.d_valid = 1'b1; b4.tap_sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            b4.d = vals[k];
            chk("lat_q_valid_pre", 32'(b4.q_valid), 0);
            tick;
            chk("fill_step", 32'(b4.fill_cnt), 32'(k + 1));
        end
        chk("lat_q",         32'(b4.q),         'hA1);
        chk("lat_q_valid",   32'(b4.q_valid),   1);
        chk("lat_full",      32'(b4.full),      1);
        chk("tap0_q",        32'(b4.tap_q),     'hD4);
        chk("tap0_valid",    32'(b4.tap_valid), 1);
        b4.tap_sel = 2'd1; #1;
        chk("tap1_q",        32'(b4.tap_q),     'hC3);
        b4.tap_sel = 2'd0;

        // Stall then drain
        b4.en = 1'b0; b4.d = 8'hEE; b4.d_valid = 1'b1;
        repeat (3) tick;
        chk("stall_q",    32'(b4.q),        'hA1);
        chk("stall_fill", 32'(b4.fill_cnt), 4);
        b4.en = 1'b1; b4.d_valid = 1'b0;
        tick; chk("drain_q1", 32'(b4.q), 'hB2); chk("drain_f1", 32'(b4.fill_cnt), 3);
        tick; chk("drain_q2", 32'(b4.q), 'hC3); chk("drain_f2", 32'(b4.fill_cnt), 2);
        tick; chk("drain_q3", 32'(b4.q), 'hD4); chk("drain_f3", 32'(b4.fill_cnt), 1);
        tick;
        chk("drain_q_valid", 32'(b4.q_valid),  0);
        chk("drain_f4",      32'(b4.fill_cnt), 0);
        chk("drain_empty",   32'(b4.empty),    1);

        // Refill, then rotate
        b4.d_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b4.d = vals[k];
            tick;
        end
        chk("refill_full", 32'(b4.full), 1);
        b4.rotate = 1'b1; b4.d_valid = 1'b0; b4.d = 8'h00;
        tick;
        chk("rot1_q",     32'(b4.q),        'hB2);
        chk("rot1_tap0",  32'(b4.tap_q),    'hA1);
        chk("rot1_fill",  32'(b4.fill_cnt), 4);
        repeat (3) tick;
        chk("rot4_q",     32'(b4.q),        'hA1);
        chk("rot4_fill",  32'(b4.fill_cnt), 4);
        chk("rot4_tap0",  32'(b4.tap_q),    'hD4);
        b4.en = 1'b0; b4.d_valid = 1'b1;
        tick;
        chk("rot_hold_q", 32'(b4.q), 'hA1);

        // Flush priority
        b4.en = 1'b1; b4.rotate = 1'b0; b4.flush = 1'b1; b4.d = 8'h55; b4.d_valid = 1'b1;
        tick;
        chk("flush_fill",      32'(b4.fill_cnt),  0);
        chk("flush_q_valid",   32'(b4.q_valid),   0);
        chk("flush_q",         32'(b4.q),         'hA1);
        chk("flush_empty",     32'(b4.empty),     1);
        chk("flush_tap_q",     32'(b4.tap_q),     'hD4);
        chk("flush_tap_valid", 32'(b4.tap_valid), 0);
        b4.flush = 1'b0;

        // Mixed valid pattern tracks popcount
        for (int k = 0; k < 5; k++) begin
            b4.d = pv_d[k]; b4.d_valid = pv_v[k];
            tick;
            chk("mix_fill", 32'(b4.fill_cnt), 32'(pv_f[k]));
        end
        chk("mix_q",       32'(b4.q),       'h62);
        chk("mix_q_valid", 32'(b4.q_valid), 0);
        b4.en = 1'b0;

        // Tap range at DEPTH=5
        b5.en = 1'b1; b5.d_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            b5.d = 8'(k);
            tick;
        end
        chk("d5_fill", 32'(b5.fill_cnt), 5);
        chk("d5_full", 32'(b5.full),     1);
        chk("d5_q",    32'(b5.q),        1);
        b5.en = 1'b0;
        b5.tap_sel = 3'd7; #1;
        chk("d5_tap7_q",     32'(b5.tap_q),     0);
        chk("d5_tap7_valid", 32'(b5.tap_valid), 0);
        b5.tap_sel = 3'd5; #1;
        chk("d5_tap5_q",     32'(b5.tap_q),     0);
        b5.tap_sel = 3'd4; #1;
        chk("d5_tap4_q",     32'(b5.tap_q),     32'(b5.q));
        chk("d5_tap4_valid", 32'(b5.tap_valid), 1);
        b5.tap_sel = 3'd2; #1;
        chk("d5_tap2_q",     32'(b5.tap_q),     3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
